// File: rtl/time_dmr_pkg.sv
// Types and helpers shared by the start and end stages of the time-DMR pair.
package time_dmr_pkg;

  typedef enum logic [0:0] {EMPTY = 1'b0, HELD = 1'b1} dmr_state_e;

  // The ID's MSB carries the XOR of its lower bits; w is the real ID width.
  function automatic logic id_ok(input logic [31:0] id, input int w);
    logic p;
    p = 1'b0;
    for (int i = 0; i < w - 1; i++) p ^= id[i];
    return id[w-1] == p;
  endfunction

endpackage

// File: rtl/time_dmr_out_reg.sv
// Single-entry valid/ready result register for {data, id, fault}.
module time_dmr_out_reg #(
  parameter type DataType = logic,
  parameter int  IDSize   = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              load_i,
  input  DataType           data_i,
  input  logic [IDSize-1:0] id_i,
  input  logic              fault_i,
  output logic              can_load_o,
  output logic              valid_o,
  output DataType           data_o,
  output logic [IDSize-1:0] id_o,
  output logic              fault_o,
  input  logic              ready_i
);

  // Loadable when empty or being drained this cycle.
  assign can_load_o = !valid_o || ready_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_o <= 1'b0;
      data_o  <= '0;
      id_o    <= '0;
      fault_o <= 1'b0;
    end else if (load_i) begin
      valid_o <= 1'b1;
      data_o  <= data_i;
      id_o    <= id_i;
      fault_o <= fault_i;
    end else if (ready_i) begin
      valid_o <= 1'b0;
    end
  end

endmodule

// File: rtl/time_dmr_end.sv
// Downstream end of the time-DMR pair: pairs copies by ID, compares them and
// emits one result per pair with a fault flag and a saturating fault counter.
module time_dmr_end
  import time_dmr_pkg::*;
#(
  parameter type DataType   = logic,
  parameter int  IDSize     = 2,
  parameter int  CountWidth = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  enable_i,
  input  DataType               data_i,
  input  logic [IDSize-1:0]     id_i,
  input  logic                  valid_i,
  output logic                  ready_o,
  output DataType               data_o,
  output logic [IDSize-1:0]     id_o,
  output logic                  fault_o,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic [CountWidth-1:0] fault_count_o
);

  dmr_state_e        state, state_n;
  DataType           h_data;
  logic [IDSize-1:0] h_id;
  logic              h_load;

  logic              can_load, or_load, or_fault;
  DataType           or_data;
  logic [IDSize-1:0] or_id;
  logic              id_in_ok;

  assign id_in_ok = id_ok(32'(id_i), IDSize);

  always_comb begin
    state_n  = state;
    ready_o  = 1'b0;
    h_load   = 1'b0;
    or_load  = 1'b0;
    or_data  = data_i;
    or_id    = id_i;
    or_fault = 1'b0;
    case (state)
      EMPTY: begin
        if (enable_i) begin
          ready_o = 1'b1;
          if (valid_i) begin
            h_load  = 1'b1;
            state_n = HELD;
          end
        end else begin
          ready_o = can_load;
          if (valid_i && can_load) begin
            or_load  = 1'b1;
            or_fault = !id_in_ok;
          end
        end
      end
      HELD: begin
        // Pairing still applies here even if enable_i has since dropped.
        ready_o = can_load;
        if (valid_i && can_load) begin
          or_load = 1'b1;
          or_data = h_data;
          or_id   = h_id;
          if (id_i == h_id) begin
            or_fault = (data_i != h_data) || !id_in_ok;
            state_n  = EMPTY;
          end else begin
            // Orphan: emit the held copy as faulty and keep the new one.
            or_fault = 1'b1;
            h_load   = 1'b1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state  <= EMPTY;
      h_data <= '0;
      h_id   <= '0;
    end else begin
      state <= state_n;
      if (h_load) begin
        h_data <= data_i;
        h_id   <= id_i;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i)
      fault_count_o <= '0;
    else if (valid_o && ready_i && fault_o && (fault_count_o != '1))
      fault_count_o <= fault_count_o + 1'b1;
  end

  time_dmr_out_reg #(.DataType(DataType), .IDSize(IDSize)) u_out_reg (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .load_i     (or_load),
    .data_i     (or_data),
    .id_i       (or_id),
    .fault_i    (or_fault),
    .can_load_o (can_load),
    .valid_o    (valid_o),
    .data_o     (data_o),
    .id_o       (id_o),
    .fault_o    (fault_o),
    .ready_i    (ready_i)
  );

endmodule

// File: tb/tb_time_dmr_end.sv
// Directed bench for time_dmr_end: pairing, orphans, parity, backpressure, bypass, saturation.
module tb_time_dmr_end;

  logic       clk = 1'b0;
  logic       rst_i, enable_i, valid_i, ready_i;
  logic [7:0] data_i, data_o;
  logic [1:0] id_i, id_o;
  logic       ready_o, fault_o, valid_o;
  logic [7:0] fault_count_o;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  logic [10:0] q[$];

  time_dmr_end #(.DataType(logic [7:0]), .IDSize(2), .CountWidth(8)) dut (
    .clk_i(clk), .rst_i(rst_i), .enable_i(enable_i), .data_i(data_i), .id_i(id_i),
    .valid_i(valid_i), .ready_o(ready_o), .data_o(data_o), .id_o(id_o),
    .fault_o(fault_o), .valid_o(valid_o), .ready_i(ready_i), .fault_count_o(fault_count_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Inputs change 1 after posedge, so a negedge sample shows what the next edge takes.
  always @(negedge clk)
    if (!rst_i && valid_o && ready_i) q.push_back({data_o, id_o, fault_o});

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Presents one beat and returns 1 after the edge that accepted it; valid_i stays high.
  task automatic beat(input logic [7:0] d, input logic [1:0] id);
    logic ok;
    ok = 1'b0;
    valid_i = 1'b1; data_i = d; id_i = id;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk); ok = ready_o;
      @(posedge clk); #1;
    end
    n_cmp++;
    if (!ok) begin n_bad++; $display("FAIL beat_hs: data %0h id %0d not accepted in 20 cycles", d, id); end
  endtask

  task automatic test_reset;
    rst_i = 1'b1; enable_i = 1'b1; valid_i = 1'b0; ready_i = 1'b1; data_i = '0; id_i = '0;
    idle(2);
    rst_i = 1'b0;
    idle(1);
    n_cmp++; if (valid_o !== 1'b0) begin n_bad++; $display("FAIL rst_valid: got %b want 0", valid_o); end
    n_cmp++; if ({data_o, id_o, fault_o} !== 11'h0) begin n_bad++; $display("FAIL rst_out: got %h want 0", {data_o, id_o, fault_o}); end
    n_cmp++; if (fault_count_o !== 8'd0) begin n_bad++; $display("FAIL rst_cnt: got %0d want 0", fault_count_o); end
    n_cmp++; if (ready_o !== 1'b1) begin n_bad++; $display("FAIL rst_ready: got %b want 1", ready_o); end
  endtask

  task automatic test_match;
    q.delete();
    beat(8'hA5, 2'd3);
    valid_i = 1'b0;
    n_cmp++; if (valid_o !== 1'b0) begin n_bad++; $display("FAIL match_first_silent: got %b want 0", valid_o); end
    beat(8'hA5, 2'd3);
    valid_i = 1'b0;
    n_cmp++; if ({valid_o, data_o, id_o, fault_o} !== {1'b1, 8'hA5, 2'd3, 1'b0})
      begin n_bad++; $display("FAIL match_out: got %h want %h", {valid_o, data_o, id_o, fault_o}, {1'b1, 8'hA5, 2'd3, 1'b0}); end
    idle(1);
    n_cmp++; if (valid_o !== 1'b0) begin n_bad++; $display("FAIL match_drain: got %b want 0", valid_o); end
    n_cmp++; if (fault_count_o !== 8'd0) begin n_bad++; $display("FAIL match_cnt: got %0d want 0", fault_count_o); end
    n_cmp++; if (q.size() !== 1) begin n_bad++; $display("FAIL match_count_results: got %0d want 1", q.size()); end
  endtask

  task automatic test_mismatch;
    beat(8'hA5, 2'd3);
    beat(8'hA4, 2'd3);
    valid_i = 1'b0;
    n_cmp++; if ({valid_o, data_o, id_o, fault_o} !== {1'b1, 8'hA5, 2'd3, 1'b1})
      begin n_bad++; $display("FAIL mismatch_out: got %h want %h", {valid_o, data_o, id_o, fault_o}, {1'b1, 8'hA5, 2'd3, 1'b1}); end
    idle(1);
    n_cmp++; if (fault_count_o !== 8'd1) begin n_bad++; $display("FAIL mismatch_cnt: got %0d want 1", fault_count_o); end
  endtask

  task automatic test_orphan;
    logic [10:0] e;
    q.delete();
    beat(8'h11, 2'd3);
    beat(8'h22, 2'd0);
    beat(8'h22, 2'd0);
    valid_i = 1'b0;
    idle(2);
    n_cmp++; if (q.size() !== 2) begin n_bad++; $display("FAIL orphan_n: got %0d want 2", q.size()); end
    if (q.size() == 2) begin
      e = q.pop_front();
      n_cmp++; if (e !== {8'h11, 2'd3, 1'b1}) begin n_bad++; $display("FAIL orphan_r0: got %h want %h", e, {8'h11, 2'd3, 1'b1}); end
      e = q.pop_front();
      n_cmp++; if (e !== {8'h22, 2'd0, 1'b0}) begin n_bad++; $display("FAIL orphan_r1: got %h want %h", e, {8'h22, 2'd0, 1'b0}); end
    end
    n_cmp++; if (fault_count_o !== 8'd2) begin n_bad++; $display("FAIL orphan_cnt: got %0d want 2", fault_count_o); end
  endtask

  task automatic test_bad_parity;
    beat(8'h5A, 2'd1);
    beat(8'h5A, 2'd1);
    valid_i = 1'b0;
    n_cmp++; if ({valid_o, data_o, id_o, fault_o} !== {1'b1, 8'h5A, 2'd1, 1'b1})
      begin n_bad++; $display("FAIL parity_out: got %h want %h", {valid_o, data_o, id_o, fault_o}, {1'b1, 8'h5A, 2'd1, 1'b1}); end
    idle(1);
    n_cmp++; if (fault_count_o !== 8'd3) begin n_bad++; $display("FAIL parity_cnt: got %0d want 3", fault_count_o); end
  endtask

  task automatic test_backpressure;
    logic [10:0] e;
    q.delete();
    ready_i = 1'b0;
    beat(8'h33, 2'd0);
    beat(8'h33, 2'd0);
    beat(8'h44, 2'd3);
    // Matching copy waits on a full output register.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_cmp++; if ({ready_o, valid_o, data_o} !== {1'b0, 1'b1, 8'h33})
        begin n_bad++; $display("FAIL bp_stall%0d: got %h want %h", i, {ready_o, valid_o, data_o}, {1'b0, 1'b1, 8'h33}); end
      @(posedge clk); #1;
    end
    ready_i = 1'b1;
    @(negedge clk);
    n_cmp++; if (ready_o !== 1'b1) begin n_bad++; $display("FAIL bp_release: got %b want 1", ready_o); end
    @(posedge clk); #1;
    valid_i = 1'b0;
    idle(2);
    n_cmp++; if (q.size() !== 2) begin n_bad++; $display("FAIL bp_n: got %0d want 2", q.size()); end
    if (q.size() == 2) begin
      e = q.pop_front();
      n_cmp++; if (e !== {8'h33, 2'd0, 1'b0}) begin n_bad++; $display("FAIL bp_r0: got %h want %h", e, {8'h33, 2'd0, 1'b0}); end
      e = q.pop_front();
      n_cmp++; if (e !== {8'h44, 2'd3, 1'b0}) begin n_bad++; $display("FAIL bp_r1: got %h want %h", e, {8'h44, 2'd3, 1'b0}); end
    end
    n_cmp++; if (fault_count_o !== 8'd3) begin n_bad++; $display("FAIL bp_cnt: got %0d want 3", fault_count_o); end
  endtask

  task automatic test_back_to_back;
    int t0;
    q.delete();
    t0 = cyc;
    beat(8'h10, 2'd0);
    beat(8'h10, 2'd0);
    beat(8'h20, 2'd3);
    beat(8'h20, 2'd3);
    valid_i = 1'b0;
    n_cmp++; if (cyc - t0 !== 4) begin n_bad++; $display("FAIL b2b_cycles: got %0d want 4", cyc - t0); end
    idle(2);
    n_cmp++; if (q.size() !== 2) begin n_bad++; $display("FAIL b2b_n: got %0d want 2", q.size()); end
    if (q.size() == 2) begin
      n_cmp++; if (q[0] !== {8'h10, 2'd0, 1'b0} || q[1] !== {8'h20, 2'd3, 1'b0})
        begin n_bad++; $display("FAIL b2b_res: got %h %h want %h %h", q[0], q[1], {8'h10, 2'd0, 1'b0}, {8'h20, 2'd3, 1'b0}); end
    end
  endtask

  task automatic test_disabled;
    int t0;
    q.delete();
    enable_i = 1'b0;
    t0 = cyc;
    beat(8'h01, 2'd0);
    beat(8'h02, 2'd3);
    beat(8'h03, 2'd1);
    valid_i = 1'b0;
    n_cmp++; if (cyc - t0 !== 3) begin n_bad++; $display("FAIL dis_cycles: got %0d want 3", cyc - t0); end
    idle(2);
    n_cmp++; if (q.size() !== 3) begin n_bad++; $display("FAIL dis_n: got %0d want 3", q.size()); end
    if (q.size() == 3) begin
      n_cmp++; if (q[0] !== {8'h01, 2'd0, 1'b0} || q[1] !== {8'h02, 2'd3, 1'b0} || q[2] !== {8'h03, 2'd1, 1'b1})
        begin n_bad++; $display("FAIL dis_res: got %h %h %h", q[0], q[1], q[2]); end
    end
    n_cmp++; if (fault_count_o !== 8'd4) begin n_bad++; $display("FAIL dis_cnt: got %0d want 4", fault_count_o); end
    enable_i = 1'b1;
  endtask

  task automatic test_reset_mid_held;
    beat(8'h77, 2'd0);
    valid_i = 1'b0;
    rst_i = 1'b1;
    idle(1);
    rst_i = 1'b0;
    n_cmp++; if ({valid_o, fault_count_o} !== 9'h0) begin n_bad++; $display("FAIL rmid_state: got %h want 0", {valid_o, fault_count_o}); end
    q.delete();
    beat(8'h88, 2'd3);
    valid_i = 1'b0;
    n_cmp++; if (valid_o !== 1'b0) begin n_bad++; $display("FAIL rmid_first: got %b want 0", valid_o); end
    beat(8'h88, 2'd3);
    valid_i = 1'b0;
    idle(2);
    n_cmp++; if (q.size() !== 1) begin n_bad++; $display("FAIL rmid_n: got %0d want 1", q.size()); end
    if (q.size() == 1) begin
      n_cmp++; if (q[0] !== {8'h88, 2'd3, 1'b0}) begin n_bad++; $display("FAIL rmid_res: got %h want %h", q[0], {8'h88, 2'd3, 1'b0}); end
    end
  endtask

  task automatic test_saturation;
    enable_i = 1'b0;
    for (int i = 0; i < 300; i++) beat(8'(i), 2'd1);
    valid_i = 1'b0;
    idle(2);
    n_cmp++; if (fault_count_o !== 8'd255) begin n_bad++; $display("FAIL sat_cnt: got %0d want 255", fault_count_o); end
    enable_i = 1'b1;
  endtask

  initial begin
    test_reset;
    test_match;
    test_mismatch;
    test_orphan;
    test_bad_parity;
    test_backpressure;
    test_back_to_back;
    test_disabled;
    test_reset_mid_held;
    test_saturation;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
